// File: rtl/mem_issue_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_issue_queue_if
// Description : Bundle of the dispatch, load/store-unit and writeback signals
//               around mem_issue_queue.
//               master = producer / load-store-unit side (testbench)
//               slave  = the issue queue itself
// Ports       : in0_*/in1_*  dispatch slots (slot 0 program-older)
//               in_ready     at least two queue entries free
//               mem_*        registered strobes/operands to the LSU,
//                            mem_read_data returned from the LSU
//               wb_*         load writeback
//               count        current queue occupancy
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_issue_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in0_valid;
  logic              in1_valid;
  logic              in0_is_store;
  logic              in1_is_store;
  logic [31:0]       in0_base;
  logic [31:0]       in1_base;
  logic [11:0]       in0_offset;
  logic [11:0]       in1_offset;
  logic [31:0]       in0_wdata;
  logic [31:0]       in1_wdata;
  logic [4:0]        in0_rd;
  logic [4:0]        in1_rd;
  logic              in_ready;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_address;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;
  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;
  logic [CNT_W-1:0]  count;

  modport master (
    output in0_valid, in1_valid, in0_is_store, in1_is_store,
           in0_base, in1_base, in0_offset, in1_offset,
           in0_wdata, in1_wdata, in0_rd, in1_rd, mem_read_data,
    input  in_ready, mem_read, mem_write, mem_address, mem_write_data,
           wb_valid, wb_rd, wb_data, count
  );

  modport slave (
    input  in0_valid, in1_valid, in0_is_store, in1_is_store,
           in0_base, in1_base, in0_offset, in1_offset,
           in0_wdata, in1_wdata, in0_rd, in1_rd, mem_read_data,
    output in_ready, mem_read, mem_write, mem_address, mem_write_data,
           wb_valid, wb_rd, wb_data, count
  );
endinterface
`default_nettype wire

// File: rtl/mem_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : mem_issue_queue
// Description : In-order memory-op issue queue. Accepts up to two dispatched
//               loads/stores per cycle, computes the truncated effective
//               address at enqueue, issues one op per cycle to the load/store
//               unit through registered mem_* outputs and returns load data
//               on the wb_* outputs two cycles after the op was on mem_*.
// Ports       : clk       rising-edge clock
//               rst_n     asynchronous active-low reset
//               bus       mem_issue_queue_if.slave (dispatch, LSU, writeback,
//                         in_ready, count)
// Parameters  : DEPTH     queue entries (power of two, >= 2)
//               ADDR_W    significant data-memory address bits
// Options     : MEMQ_BYPASS_EN - when defined, an op enqueued into an empty
//               queue goes straight into the mem_* registers (one cycle less
//               latency); otherwise every op passes through the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_issue_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [31:0] ADDR_MASK = (ADDR_W >= 32) ? 32'hFFFF_FFFF
                                                     : ((32'd1 << ADDR_W) - 32'd1);

  typedef struct packed {
    logic        is_store;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } op_t;

  // Base plus sign-extended offset, wrapped to 32 bits, then cut down to the
  // addressable memory range.
  function automatic logic [31:0] eff_addr(input logic [31:0] base,
                                           input logic [11:0] off);
    return (base + {{20{off[11]}}, off}) & ADDR_MASK;
  endfunction

  // Queue state
  op_t              q_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Issue stage registers
  logic        mem_read_r;
  logic        mem_write_r;
  logic [31:0] mem_address_r;
  logic [31:0] mem_write_data_r;
  logic [4:0]  issued_rd;

  // Writeback pipeline: one stage waiting for the LSU data, one output stage
  logic        rd_pending;
  logic [4:0]  pending_rd;
  logic        wb_valid_r;
  logic [4:0]  wb_rd_r;
  logic [31:0] wb_data_r;

  // Combinational control
  op_t              slot0;
  op_t              slot1;
  op_t              bypass_op;
  op_t              issue_op;
  logic             in_ready;
  logic             enq0;
  logic             enq1;
  logic             pop;
  logic             bypass;
  logic             q0;
  logic             q1;
  logic             issue;
  logic [CNT_W-1:0] count_next;

  assign slot0 = '{is_store: bus.in0_is_store,
                   addr:     eff_addr(bus.in0_base, bus.in0_offset),
                   wdata:    bus.in0_wdata,
                   rd:       bus.in0_rd};
  assign slot1 = '{is_store: bus.in1_is_store,
                   addr:     eff_addr(bus.in1_base, bus.in1_offset),
                   wdata:    bus.in1_wdata,
                   rd:       bus.in1_rd};

  // Two free entries are required so a full dual dispatch always fits.
  assign in_ready = ((DEPTH_C - count) >= CNT_W'(2));

  always_comb begin
    enq0      = in_ready & bus.in0_valid;
    enq1      = in_ready & bus.in1_valid;
    pop       = (count != '0);
`ifdef MEMQ_BYPASS_EN
    // Only when nothing is being popped can the oldest new op skip the queue.
    bypass    = ~pop & (enq0 | enq1);
`else
    bypass    = 1'b0;
`endif
    bypass_op = enq0 ? slot0 : slot1;
    // Slot 1 is queued unless it was the single op that took the bypass.
    q0        = enq0 & ~bypass;
    q1        = enq1 & ~(bypass & ~enq0);
    issue     = pop | bypass;
    issue_op  = pop ? q_mem[rd_ptr] : bypass_op;
    count_next = count + CNT_W'(q0) + CNT_W'(q1) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (q0) begin
        q_mem[wr_ptr] <= slot0;
      end
      // Slot 1 lands right behind slot 0 if both are queued.
      if (q1) begin
        q_mem[wr_ptr + PTR_W'(q0)] <= slot1;
      end
      wr_ptr <= wr_ptr + PTR_W'(q0) + PTR_W'(q1);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read_r       <= 1'b0;
      mem_write_r      <= 1'b0;
      mem_address_r    <= '0;
      mem_write_data_r <= '0;
      issued_rd        <= '0;
    end else begin
      mem_read_r       <= issue & ~issue_op.is_store;
      mem_write_r      <= issue &  issue_op.is_store;
      mem_address_r    <= issue ? issue_op.addr : '0;
      mem_write_data_r <= (issue & issue_op.is_store) ? issue_op.wdata : '0;
      issued_rd        <= (issue & ~issue_op.is_store) ? issue_op.rd : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending <= 1'b0;
      pending_rd <= '0;
      wb_valid_r <= 1'b0;
      wb_rd_r    <= '0;
      wb_data_r  <= '0;
    end else begin
      rd_pending <= mem_read_r;
      pending_rd <= issued_rd;
      // The LSU result is valid in the cycle after the read strobe.
      wb_valid_r <= rd_pending;
      wb_rd_r    <= rd_pending ? pending_rd : '0;
      wb_data_r  <= rd_pending ? bus.mem_read_data : '0;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.count          = count;
  assign bus.mem_read       = mem_read_r;
  assign bus.mem_write      = mem_write_r;
  assign bus.mem_address    = mem_address_r;
  assign bus.mem_write_data = mem_write_data_r;
  assign bus.wb_valid       = wb_valid_r;
  assign bus.wb_rd          = wb_rd_r;
  assign bus.wb_data        = wb_data_r;

endmodule
`default_nettype wire

// File: tb/tb_mem_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_issue_queue
// Description : Self-checking bench for mem_issue_queue. A queue-based model
//               predicts in_ready, count, mem_* and wb_* every cycle; directed
//               sequences pin the model with literal expectations, followed by
//               randomized dual-slot traffic with occasional resets.
// Options     : MEMQ_BYPASS_EN selects the bypass build expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_issue_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 5;
`ifdef MEMQ_BYPASS_EN
  localparam int LAT = 1;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit BYP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_issue_queue_if #(.DEPTH(DEPTH)) bus ();

  mem_issue_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int saw_low = 0;
  int max_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    bit        st;
    bit [31:0] addr;
    bit [31:0] wd;
    bit [4:0]  rd;
  } op_t;

  op_t       mq[$];
  op_t       acc[$];
  op_t       nx;
  bit        nx_v;
  bit        e_mr, e_mw;
  bit [31:0] e_ma, e_mwd;
  bit [4:0]  e_mrd;
  bit        p_v;
  bit [4:0]  p_rd;
  bit        e_wv;
  bit [4:0]  e_wrd;
  bit [31:0] e_wd;

  function automatic bit [31:0] model_addr(input bit [31:0] base, input bit [11:0] off);
    longint o;
    longint s;
    longint m;
    o = longint'(off);
    if (o >= 2048) o = o - 4096;
    m = longint'(1) << ADDR_W;
    s = (longint'(base) + o) % m;
    if (s < 0) s = s + m;
    return 32'(s);
  endfunction

  function automatic op_t mk_op(input int s);
    op_t o;
    if (s == 0) begin
      o.st = bus.in0_is_store; o.addr = model_addr(bus.in0_base, bus.in0_offset);
      o.wd = bus.in0_wdata;    o.rd = bus.in0_rd;
    end else begin
      o.st = bus.in1_is_store; o.addr = model_addr(bus.in1_base, bus.in1_offset);
      o.wd = bus.in1_wdata;    o.rd = bus.in1_rd;
    end
    return o;
  endfunction

  task automatic model_reset();
    mq.delete();
    e_mr = 0; e_mw = 0; e_ma = 0; e_mwd = 0; e_mrd = 0;
    p_v = 0; p_rd = 0; e_wv = 0; e_wrd = 0; e_wd = 0;
  endtask

  // Compare against the model, then advance the model with the inputs the
  // DUT will sample at the coming rising edge.
  always @(negedge clk) begin : p_compare
    if (!rst_n) model_reset();
    chk("in_ready", bus.in_ready, (DEPTH - mq.size()) >= 2);
    chk("count", bus.count, mq.size());
    chk("count_bound", bus.count <= DEPTH, 1);
    chk("mem_read", bus.mem_read, e_mr);
    chk("mem_write", bus.mem_write, e_mw);
    if (e_mr || e_mw) chk("mem_address", bus.mem_address, e_ma);
    if (e_mw) chk("mem_write_data", bus.mem_write_data, e_mwd);
    chk("wb_valid", bus.wb_valid, e_wv);
    if (e_wv) begin
      chk("wb_rd", bus.wb_rd, e_wrd);
      chk("wb_data", bus.wb_data, e_wd);
    end
    if (rst_n) begin
      e_wv  = p_v;
      e_wrd = p_rd;
      e_wd  = bus.mem_read_data;
      p_v   = e_mr;
      p_rd  = e_mrd;
      acc.delete();
      if ((DEPTH - mq.size()) >= 2) begin
        if (bus.in0_valid) acc.push_back(mk_op(0));
        if (bus.in1_valid) acc.push_back(mk_op(1));
      end
      nx_v = 0;
      nx   = '0;
      if (mq.size() > 0) begin
        nx = mq.pop_front(); nx_v = 1;
      end else if (BYP && acc.size() > 0) begin
        nx = acc.pop_front(); nx_v = 1;
      end
      foreach (acc[i]) mq.push_back(acc[i]);
      e_mr  = nx_v && !nx.st;
      e_mw  = nx_v && nx.st;
      e_ma  = nx.addr;
      e_mwd = nx.wd;
      e_mrd = nx.rd;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_slot(input int s, input bit v, input bit st, input bit [31:0] base,
                          input bit [11:0] off, input bit [31:0] wd, input bit [4:0] rd);
    if (s == 0) begin
      bus.in0_valid = v; bus.in0_is_store = st; bus.in0_base = base;
      bus.in0_offset = off; bus.in0_wdata = wd; bus.in0_rd = rd;
    end else begin
      bus.in1_valid = v; bus.in1_is_store = st; bus.in1_base = base;
      bus.in1_offset = off; bus.in1_wdata = wd; bus.in1_rd = rd;
    end
  endtask

  task automatic clear_slots();
    set_slot(0, 0, 0, 0, 0, 0, 0);
    set_slot(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    clear_slots();
    repeat (n) next_cyc();
  endtask

  task automatic rand_slot(input int s, input bit v);
    bit [31:0] base;
    base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom;
    set_slot(s, v, 1'($urandom_range(0, 1)), base, 12'($urandom), $urandom, 5'($urandom));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_count"}, bus.count, 0);
    chk({tag, "_mem_read"}, bus.mem_read, 0);
    chk({tag, "_mem_write"}, bus.mem_write, 0);
    chk({tag, "_mem_address"}, bus.mem_address, 0);
    chk({tag, "_mem_write_data"}, bus.mem_write_data, 0);
    chk({tag, "_wb_valid"}, bus.wb_valid, 0);
    chk({tag, "_wb_rd"}, bus.wb_rd, 0);
    chk({tag, "_wb_data"}, bus.wb_data, 0);
  endtask

  // Producer holds its slots while in_ready is low.
  task automatic run_traffic(input int ncyc, input int pv, input int prst);
    bit hold;
    hold = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (prst > 0 && $urandom_range(0, 999) < prst) begin
        clear_slots();
        rst_n = 1'b0;
        #1 check_reset_outputs("rand_rst");
        next_cyc();
        rst_n = 1'b1;
        hold  = 0;
      end else begin
        if (!hold) begin
          rand_slot(0, $urandom_range(0, 99) < pv);
          rand_slot(1, $urandom_range(0, 99) < pv);
        end
        bus.mem_read_data = $urandom;
        @(negedge clk);
        hold = !bus.in_ready && (bus.in0_valid || bus.in1_valid);
        if (!bus.in_ready) saw_low = 1;
        if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
        next_cyc();
      end
    end
    clear_slots();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    clear_slots();
    bus.mem_read_data = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("por");
    rst_n = 1'b1;
    next_cyc();

    // Single load: 0x10 + (-4) = 0x0C
    set_slot(0, 1, 0, 32'h10, 12'hFFC, 0, 5'd3);
    next_cyc();
    clear_slots();
    repeat (LAT - 1) next_cyc();
    @(negedge clk);
    chk("ld_mem_read", bus.mem_read, 1);
    chk("ld_mem_write", bus.mem_write, 0);
    chk("ld_mem_address", bus.mem_address, 32'h0C);
    next_cyc();
    bus.mem_read_data = 32'hDEAD;
    next_cyc();
    bus.mem_read_data = 0;
    @(negedge clk);
    chk("ld_wb_valid", bus.wb_valid, 1);
    chk("ld_wb_rd", bus.wb_rd, 3);
    chk("ld_wb_data", bus.wb_data, 32'hDEAD);
    next_cyc();
    idle(4);

    // Dual dispatch: store (0x1+0x2) then load rd=7 at 0x8
    set_slot(0, 1, 1, 32'h1, 12'h002, 32'h55, 0);
    set_slot(1, 1, 0, 32'h8, 12'h000, 0, 5'd7);
    next_cyc();
    clear_slots();
    repeat (LAT - 1) next_cyc();
    @(negedge clk);
    chk("dual_st_write", bus.mem_write, 1);
    chk("dual_st_read", bus.mem_read, 0);
    chk("dual_st_addr", bus.mem_address, 32'h3);
    chk("dual_st_wdata", bus.mem_write_data, 32'h55);
    next_cyc();
    @(negedge clk);
    chk("dual_ld_read", bus.mem_read, 1);
    chk("dual_ld_addr", bus.mem_address, 32'h8);
    next_cyc();
    bus.mem_read_data = 32'h77;
    @(negedge clk);
    chk("dual_no_st_wb", bus.wb_valid, 0);
    next_cyc();
    bus.mem_read_data = 0;
    @(negedge clk);
    chk("dual_wb_valid", bus.wb_valid, 1);
    chk("dual_wb_rd", bus.wb_rd, 7);
    chk("dual_wb_data", bus.wb_data, 32'h77);
    next_cyc();
    @(negedge clk);
    chk("dual_one_pulse", bus.wb_valid, 0);
    next_cyc();
    idle(4);

    // Address truncation: 0xFFFFFFF0 + 0x7FF = 0x7EF -> 0x0F
    set_slot(0, 1, 1, 32'hFFFF_FFF0, 12'h7FF, 32'hA5, 0);
    next_cyc();
    clear_slots();
    repeat (LAT - 1) next_cyc();
    @(negedge clk);
    chk("trunc_write", bus.mem_write, 1);
    chk("trunc_addr", bus.mem_address, 32'h0F);
    next_cyc();
    idle(4);

    // Reset with three loads queued and one on the LSU path
    set_slot(0, 1, 0, 32'h0, 12'h001, 0, 5'd1);
    set_slot(1, 1, 0, 32'h0, 12'h002, 0, 5'd2);
    next_cyc();
    set_slot(0, 1, 0, 32'h0, 12'h003, 0, 5'd3);
    set_slot(1, 1, 0, 32'h0, 12'h004, 0, 5'd4);
    next_cyc();
    if (BYP) begin
      set_slot(0, 1, 0, 32'h0, 12'h005, 0, 5'd5);
      set_slot(1, 1, 0, 32'h0, 12'h006, 0, 5'd6);
      next_cyc();
    end
    clear_slots();
    bus.mem_read_data = 32'h1234;
    #1;
    chk("pre_rst_count", bus.count, 3);
    chk("pre_rst_mem_read", bus.mem_read, 1);
    rst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    next_cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_mem_read", bus.mem_read, 0);
      chk("post_rst_mem_write", bus.mem_write, 0);
      chk("post_rst_wb_valid", bus.wb_valid, 0);
      next_cyc();
    end
    bus.mem_read_data = 0;

    // Back-to-back dual dispatch across pointer wrap
    saw_low = 0;
    max_cnt = 0;
    run_traffic(10, 100, 0);
    chk("fill_in_ready_dropped", saw_low, 1);
    chk("fill_max_count_le_depth", max_cnt <= DEPTH, 1);
    idle(5);

    // Randomized mixed traffic with occasional resets
    run_traffic(400, 60, 15);
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/mem_issue_queue.md
MEM_ISSUE_QUEUE -- requirements
Module: mem_issue_queue

Interface
REQ-001 Parameter: DEPTH, default 4, queue entries; legal values are powers of two, at least 2.
REQ-002 Parameter: ADDR_W, default 5, significant data-memory address bits (32-word memory).
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Ports: in0_valid/in1_valid  input  1 each  dispatch slot op valid; slot 0 is program-older than slot 1.
REQ-006 Ports: in0_is_store/in1_is_store  input  1 each  1 = store, 0 = load.
REQ-007 Ports: in0_base/in1_base  input  32 each  base register value.
REQ-008 Ports: in0_offset/in1_offset  input  12 each  signed immediate offset.
REQ-009 Ports: in0_wdata/in1_wdata  input  32 each  store data; ignored for loads.
REQ-010 Ports: in0_rd/in1_rd  input  5 each  load destination register; ignored for stores.
REQ-011 Port: in_ready  output  1  high when at least 2 entries are free.
REQ-012 Ports: mem_read, mem_write  output  1 each  registered strobes to the load/store unit.
REQ-013 Ports: mem_address  output  32; mem_write_data  output  32  registered operands to the load/store unit.
REQ-014 Port: mem_read_data  input  32  registered read result from the load/store unit.
REQ-015 Ports: wb_valid  output  1; wb_rd  output  5; wb_data  output  32  load writeback.
REQ-016 Port: count  output  log2(DEPTH)+1  current occupancy.

Function
REQ-017 Enqueue: at a rising edge with in_ready=1, each valid slot is written; slot 0 goes before slot 1; in1 alone is legal.
REQ-018 Valid slots presented while in_ready=0 are ignored; the producer holds them.
REQ-019 Effective address = base + sign-extended offset, mod 2^32; bits [ADDR_W-1:0] are kept and upper bits zeroed; computed at enqueue.
REQ-020 Issue: each cycle with count>0, the head is popped and loaded into the mem_* registers, so mem_* are valid in the next cycle for exactly one cycle.
REQ-021 mem_read and mem_write are never both 1; both are 0 in every cycle with no issued op.
REQ-022 Ops issue strictly in FIFO (program) order, at most one per cycle.
REQ-023 Simultaneous enqueue and pop in one cycle: count_next = count + enqueued - popped.
REQ-024 Pointers wrap modulo DEPTH; full (count=DEPTH) and empty (count=0) are distinguished by count.
REQ-025 A load driven on mem_* in cycle N gives wb_valid=1 in cycle N+2, with wb_rd = that load's rd and wb_data = mem_read_data sampled in cycle N+1.
REQ-026 Stores produce no writeback; back-to-back loads give back-to-back wb_valid pulses.
REQ-027 Default latency: an op enqueued at the edge ending cycle t into an empty queue appears on mem_* in cycle t+2.

Reset
REQ-028 rst_n=0 immediately clears the queue, pointers, count, mem_read, mem_write, mem_address, mem_write_data, wb_valid, wb_rd and wb_data to 0; in_ready=1 while rst_n=0.
REQ-029 Reset mid-operation discards all queued ops and any in-flight writeback, with no partial pulse after release.

Configuration
REQ-030 Macro MEMQ_BYPASS_EN: when defined, an enqueue into an empty queue with no pop in progress loads the oldest valid slot directly into the mem_* registers, giving t+1 latency; any second slot is queued.
REQ-031 When MEMQ_BYPASS_EN is undefined, no bypass exists and REQ-027 latency always applies; ordering and writeback rules are identical in both builds.

Verification
REQ-032 Reset then in0 load base=0x10, offset=-4, rd=3: mem_read=1 with mem_address=0x0C in cycle t+2 (t+1 with bypass); mem_read_data=0xDEAD in the next cycle gives wb_valid=1, wb_rd=3, wb_data=0xDEAD.
REQ-033 Dual enqueue of store (base=0x1, offset=0x2, wdata=0x55) in slot 0 and load (rd=7) in slot 1: the store issues first with mem_address=3 and mem_write_data=0x55, the load issues the next cycle, and there is one wb pulse, for rd=7.
REQ-034 Fill with the pump stalled by a held mem path model for DEPTH=4: in_ready drops at count=3; valid slots offered while in_ready=0 are not enqueued; count never exceeds 4.
REQ-035 Enqueue 2 ops per cycle for 10 cycles with continuous issue: issue order matches dispatch order across pointer wrap, and count stays within 0..4.
REQ-036 Address truncation: base=0xFFFFFFF0, offset=0x7FF gives mem_address=0x0000000F.
REQ-037 Assert rst_n=0 with 3 ops queued and one load in flight: all outputs 0 immediately; after release there is no wb pulse and no mem strobe until a new enqueue.
